game_sequencer: RTL and testbench

//  Plays one N x N tic-tac-toe game by driving a single shared move-maker (make_turn-style req/ready/valid port) for both players.

---
 rtl/game_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_game_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer
//   Plays one N x N tic-tac-toe game by driving a single shared move-maker
//   (req/ready/valid handshake) for both players. The target side alternates
//   every accepted move, the current boards are fed back to the move-maker,
//   and the position is judged for win/draw after every move.
//
//   Optional feature macro: GAME_SEQ_MOVE_CHECK_EN
//     defined   - every returned move is checked for legality; an illegal
//                 move aborts the game with error=1 and the boards untouched.
//     undefined - returned boards are accepted as-is; error only follows
//                 mt_error.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start, first_a        start a game / side A moves first (sampled in IDLE)
//   init_a, init_b        initial boards, bit index = row*N+col
//   mt_ready              move-maker idle
//   mt_req, mt_target_a   one-cycle move request, side to play for
//   mt_board_a/b          current boards presented to the move-maker
//   mt_valid, mt_error    move-maker result pulse / no move found
//   mt_a_in, mt_b_in      boards returned by the move-maker
//   busy, done            game in progress / one-cycle end-of-game pulse
//   result                0 none, 1 A wins, 2 B wins, 3 draw
//   error                 game aborted
//   board_a, board_b      current/final boards
//   moves                 moves accepted this game
module game_sequencer #(
  parameter  int N  = 3,
  localparam int CW = $clog2(N*N+1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           first_a,
  input  logic [N*N-1:0] init_a,
  input  logic [N*N-1:0] init_b,
  input  logic           mt_ready,
  output logic           mt_req,
  output logic           mt_target_a,
  output logic [N*N-1:0] mt_board_a,
  output logic [N*N-1:0] mt_board_b,
  input  logic           mt_valid,
  input  logic           mt_error,
  input  logic [N*N-1:0] mt_a_in,
  input  logic [N*N-1:0] mt_b_in,
  output logic           busy,
  output logic           done,
  output logic [1:0]     result,
  output logic           error,
  output logic [N*N-1:0] board_a,
  output logic [N*N-1:0] board_b,
  output logic [CW-1:0]  moves
);

  localparam int NN = N*N;

  typedef enum logic [2:0] {
    S_IDLE,
    S_JUDGE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            turn_q;
  logic            mt_req_q;
  logic            mt_target_a_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      result_q;
  logic            error_q;
  logic [NN-1:0]   board_a_q;
  logic [NN-1:0]   board_b_q;
  logic [CW-1:0]   moves_q;

  logic            a_line;
  logic            b_line;
  logic            full;
  logic            move_ok;

  // True when b owns every cell of at least one row, column or diagonal.
  // Masks are built by shifting so no variable bit-select is needed.
  function automatic logic has_line(input logic [NN-1:0] b);
    logic [NN-1:0] m_row, m_col, m_diag, m_anti;
    logic          hit;
    hit    = 1'b0;
    m_diag = '0;
    m_anti = '0;
    for (int unsigned i = 0; i < N; i++) begin
      m_row = '0;
      m_col = '0;
      for (int unsigned j = 0; j < N; j++) begin
        m_row |= NN'(1) << (i*N + j);
        m_col |= NN'(1) << (j*N + i);
      end
      hit |= ((b & m_row) == m_row) | ((b & m_col) == m_col);
      m_diag |= NN'(1) << (i*N + i);
      m_anti |= NN'(1) << (i*N + N - 1 - i);
    end
    hit |= ((b & m_diag) == m_diag) | ((b & m_anti) == m_anti);
    return hit;
  endfunction

  always_comb begin
    a_line = has_line(board_a_q);
    b_line = has_line(board_b_q);
    full   = &(board_a_q | board_b_q);
  end

`ifdef GAME_SEQ_MOVE_CHECK_EN
  logic [NN-1:0] mov_old, mov_new, oth_old, oth_new, gain;

  // Legal move: mover keeps all its cells and gains exactly one (single set
  // bit test via gain & (gain-1)), opponent unchanged, no cell shared.
  always_comb begin
    mov_old = turn_q ? board_a_q : board_b_q;
    mov_new = turn_q ? mt_a_in   : mt_b_in;
    oth_old = turn_q ? board_b_q : board_a_q;
    oth_new = turn_q ? mt_b_in   : mt_a_in;
    gain    = mov_new & ~mov_old;
    move_ok = ((mov_new & mov_old) == mov_old) &&
              (gain != '0) &&
              ((gain & (gain - NN'(1))) == '0) &&
              (oth_new == oth_old) &&
              ((mt_a_in & mt_b_in) == '0);
  end
`else
  always_comb begin
    move_ok = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      turn_q        <= 1'b0;
      mt_req_q      <= 1'b0;
      mt_target_a_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= 2'd0;
      error_q       <= 1'b0;
      board_a_q     <= '0;
      board_b_q     <= '0;
      moves_q       <= '0;
    end else begin
      mt_req_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            board_a_q <= init_a;
            board_b_q <= init_b;
            turn_q    <= first_a;
            result_q  <= 2'd0;
            error_q   <= 1'b0;
            moves_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          // A is checked first so it wins if both sides hold a line.
          if (a_line) begin
            result_q <= 2'd1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (b_line) begin
            result_q <= 2'd2;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (full) begin
            result_q <= 2'd3;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (mt_ready) begin
            mt_req_q      <= 1'b1;
            mt_target_a_q <= turn_q;
            state_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mt_valid) begin
            if (mt_error || !move_ok) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              board_a_q <= mt_a_in;
              board_b_q <= mt_b_in;
              moves_q   <= moves_q + CW'(1);
              turn_q    <= ~turn_q;
              state_q   <= S_JUDGE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mt_req      = mt_req_q;
  assign mt_target_a = mt_target_a_q;
  assign mt_board_a  = board_a_q;
  assign mt_board_b  = board_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign error       = error_q;
  assign board_a     = board_a_q;
  assign board_b     = board_b_q;
  assign moves       = moves_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Directed bench for game_sequencer (N=3). A behavioural move-maker stub
//   answers requests by taking the lowest empty cell; expected game outcomes
//   are queued when a game is started and checked by a monitor on done.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, first_a;
  logic [8:0] init_a, init_b;
  logic       mt_ready, mt_req, mt_target_a;
  logic [8:0] mt_board_a, mt_board_b;
  logic       mt_valid, mt_error;
  logic [8:0] mt_a_in, mt_b_in;
  logic       busy, done, error;
  logic [1:0] result;
  logic [8:0] board_a, board_b;
  logic [3:0] moves;

  always #5 clk = ~clk;

  game_sequencer #(.N(3)) dut (
    .clk(clk), .reset(reset), .start(start), .first_a(first_a),
    .init_a(init_a), .init_b(init_b),
    .mt_ready(mt_ready), .mt_req(mt_req), .mt_target_a(mt_target_a),
    .mt_board_a(mt_board_a), .mt_board_b(mt_board_b),
    .mt_valid(mt_valid), .mt_error(mt_error),
    .mt_a_in(mt_a_in), .mt_b_in(mt_b_in),
    .busy(busy), .done(done), .result(result), .error(error),
    .board_a(board_a), .board_b(board_b), .moves(moves)
  );

  typedef struct {
    logic [1:0] result;
    logic       err;
    logic [8:0] a;
    logic [8:0] b;
    logic [3:0] moves;
    int         reqs;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Stub controls
  int   lat = 2;
  bit   ready_en = 1'b1;
  bit   err_once = 1'b0;
  bit   double_once = 1'b0;
  int   req_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] r, input logic e, input logic [8:0] a,
                              input logic [8:0] b, input logic [3:0] m, input int n);
    exp_t x;
    x.result = r; x.err = e; x.a = a; x.b = b; x.moves = m; x.reqs = n;
    return x;
  endfunction

  function automatic logic [8:0] lowest_empty(input logic [8:0] occ);
    for (int k = 0; k < 9; k++)
      if ((occ & (9'(1) << k)) == '0) return 9'(1) << k;
    return '0;
  endfunction

  // Move-maker stub: latches a request, answers lat cycles later.
  initial begin : stub
    bit         pend = 1'b0;
    bit         prev_req = 1'b0;
    bit         tgt = 1'b0;
    int         cnt = 0;
    logic [8:0] sa = '0, sb = '0, nb;
    mt_ready = 1'b0; mt_valid = 1'b0; mt_error = 1'b0;
    mt_a_in = '0; mt_b_in = '0;
    forever begin
      @(posedge clk); #1;
      mt_valid = 1'b0;
      mt_error = 1'b0;
      if (mt_req === 1'b1) begin
        chk("req_single_cycle", {63'd0, prev_req}, 64'd0);
        req_count++;
        pend = 1'b1; cnt = lat;
        tgt = mt_target_a; sa = mt_board_a; sb = mt_board_b;
      end else if (pend) begin
        if (cnt > 1) cnt--;
        else begin
          pend = 1'b0;
          mt_valid = 1'b1;
          if (err_once) begin
            err_once = 1'b0;
            mt_error = 1'b1;
          end else begin
            nb = lowest_empty(sa | sb);
            if (double_once) begin
              double_once = 1'b0;
              nb |= lowest_empty(sa | sb | nb);
            end
            mt_a_in = tgt ? (sa | nb) : sa;
            mt_b_in = tgt ? sb : (sb | nb);
          end
        end
      end
      prev_req = (mt_req === 1'b1);
      mt_ready = ready_en && !pend;
    end
  end

  // Scoreboard monitor: pops one expected outcome per done pulse.
  initial begin : monitor
    bit   prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        chk("done_pulse_width", {63'd0, prev_done}, 64'd0);
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL done_unexpected: got done=1 expected no pending game");
        end else begin
          e = q.pop_front();
          chk("result",  64'(result),    64'(e.result));
          chk("error",   64'(error),     64'(e.err));
          chk("board_a", 64'(board_a),   64'(e.a));
          chk("board_b", 64'(board_b),   64'(e.b));
          chk("moves",   64'(moves),     64'(e.moves));
          chk("reqs",    64'(req_count), 64'(e.reqs));
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  task automatic start_game(input logic fa, input logic [8:0] ia, input logic [8:0] ib);
    @(negedge clk);
    req_count = 0;
    first_a = fa; init_a = ia; init_b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 400);
    if (done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, result, error, board_a, board_b, moves,
                mt_req, mt_target_a, mt_board_a, mt_board_b});
  endfunction

  initial begin : main
    int cyc;
    int lowreq;
    reset = 1'b1; start = 1'b0; first_a = 1'b0; init_a = '0; init_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;

    // 1: A first, lowest-empty stub -> A takes the anti-diagonal
    q.push_back(mk(2'd1, 1'b0, 9'h055, 9'h02A, 4'd7, 7));
    start_game(1'b1, 9'h000, 9'h000);
    wait_done(cyc);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);

    // 2: B first -> B takes the anti-diagonal
    q.push_back(mk(2'd2, 1'b0, 9'h02A, 9'h055, 4'd7, 7));
    start_game(1'b0, 9'h000, 9'h000);
    wait_done(cyc);

    // 3: full board, no line -> draw, no requests, done 2 cycles after start
    q.push_back(mk(2'd3, 1'b0, 9'h163, 9'h09C, 4'd0, 0));
    start_game(1'b1, 9'h163, 9'h09C);
    wait_done(cyc);
    chk("draw_done_latency", 64'(cyc + 1), 64'd2);

    // 3b: A already won at start, B too -> A has priority, no requests
    q.push_back(mk(2'd1, 1'b0, 9'h007, 9'h038, 4'd0, 0));
    start_game(1'b0, 9'h007, 9'h038);
    wait_done(cyc);

    // 4: move-maker error on first request
    err_once = 1'b1;
    q.push_back(mk(2'd0, 1'b1, 9'h001, 9'h010, 4'd0, 1));
    start_game(1'b0, 9'h001, 9'h010);
    wait_done(cyc);

    // 5a: mt_ready low for 10 cycles, then a start pulse mid-game is ignored
    ready_en = 1'b0;
    q.push_back(mk(2'd1, 1'b0, 9'h055, 9'h02A, 4'd7, 7));
    start_game(1'b1, 9'h000, 9'h000);
    lowreq = 0;
    repeat (10) begin
      @(negedge clk);
      if (mt_req === 1'b1) lowreq++;
    end
    chk("req_while_not_ready", 64'(lowreq), 64'd0);
    chk("busy_in_game", 64'(busy), 64'd1);
    ready_en = 1'b1;
    repeat (5) @(negedge clk);
    first_a = 1'b0; init_a = 9'h1FF; init_b = 9'h000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);

    // 5b: reset while waiting for the move-maker
    lat = 20;
    start_game(1'b1, 9'h001, 9'h000);
    cyc = 0;
    while (mt_req !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_seen_before_reset", 64'(mt_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_wait_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("late_valid_ignored", 64'({busy, board_a, board_b}), 64'd0);
    lat = 2;

    // 6: mover sets two new A bits on the first request
    double_once = 1'b1;
`ifdef GAME_SEQ_MOVE_CHECK_EN
    q.push_back(mk(2'd0, 1'b1, 9'h000, 9'h000, 4'd0, 1));
`else
    q.push_back(mk(2'd2, 1'b0, 9'h02B, 9'h054, 4'd6, 6));
`endif
    start_game(1'b1, 9'h000, 9'h000);
    wait_done(cyc);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
